// File: rtl/spart_echo_driver.sv
// SPART bus master: programs the baud divisor for the selected rate, then
// reads each received byte into a small FIFO and writes it back out (echo).
module spart_echo_driver #(
  parameter logic [15:0] DB_4800    = 16'h028A,
  parameter logic [15:0] DB_9600    = 16'h0144,
  parameter logic [15:0] DB_19200   = 16'h00A2,
  parameter logic [15:0] DB_38400   = 16'h0050,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  br_cfg,
  input  logic                        rda,
  input  logic                        tbr,
  output logic                        iocs,
  output logic                        iorw,
  output logic [1:0]                  ioaddr,
  inout  wire  [7:0]                  databus,
  output logic                        cfg_done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  last_rx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_INIT,
    S_CFG_LO,
    S_CFG_HI,
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    br_meta, br_sync, cfg_br;
  logic [15:0]   db_sel, db_new;
  logic          rda_q, rx_pending;
  logic          tx_busy, tbr_low_seen, first_tx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [7:0]    dout;
  logic          fifo_full, fifo_empty;

  // br_cfg comes from switches; the synchronizer needs no reset because it
  // keeps sampling while reset is held.
  always_ff @(posedge clk) begin
    br_meta <= br_cfg;
    br_sync <= br_meta;
  end

  always_comb begin
    db_new = DB_4800;
    case (br_sync)
      2'b00:   db_new = DB_4800;
      2'b01:   db_new = DB_9600;
      2'b10:   db_new = DB_19200;
      default: db_new = DB_38400;
    endcase
  end

  assign fifo_full  = (fifo_count == CNT_FULL);
  assign fifo_empty = (fifo_count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nxt;
  end

  // S_INIT holds the bus released for the first cycle after reset so the
  // reset bus values hold asynchronously; CFG_LO follows on the first edge.
  always_comb begin
    state_nxt = state;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = 2'b01;
    dout      = '0;
    case (state)
      S_INIT: begin
        iocs      = 1'b1;
        state_nxt = S_CFG_LO;
      end
      S_CFG_LO: begin
        iorw      = 1'b0;
        ioaddr    = 2'b10;
        dout      = db_sel[7:0];
        state_nxt = S_CFG_HI;
      end
      S_CFG_HI: begin
        iorw      = 1'b0;
        ioaddr    = 2'b11;
        dout      = db_sel[15:8];
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (rx_pending)
          state_nxt = S_RD;
        else if (br_sync != cfg_br && !tx_busy)
          state_nxt = S_CFG_LO;
        else if (!fifo_empty && !tx_busy && (tbr || first_tx))
          state_nxt = S_WR;
      end
      S_RD: begin
        ioaddr    = 2'b00;
        state_nxt = S_IDLE;
      end
      S_WR: begin
        iorw      = 1'b0;
        ioaddr    = 2'b00;
        dout      = fifo_mem[rd_ptr];
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign databus = (!iocs && !iorw) ? dout : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rda_q        <= 1'b0;
      rx_pending   <= 1'b0;
      tx_busy      <= 1'b0;
      tbr_low_seen <= 1'b0;
      first_tx     <= 1'b1;
      cfg_done     <= 1'b0;
      overflow     <= 1'b0;
      cfg_br       <= '0;
      db_sel       <= '0;
      last_rx      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
    end else begin
      rda_q <= rda;
      if (rda && !rda_q)
        rx_pending <= 1'b1;
      else if (state == S_RD)
        rx_pending <= 1'b0;

      // A transmit is complete only after tbr has been seen low then high again.
      if (tx_busy) begin
        if (!tbr)              tbr_low_seen <= 1'b1;
        else if (tbr_low_seen) tx_busy      <= 1'b0;
      end

      if (state_nxt == S_CFG_LO && state != S_CFG_LO) begin
        db_sel   <= db_new;
        cfg_br   <= br_sync;
        cfg_done <= 1'b0;
      end

      case (state)
        S_CFG_HI: cfg_done <= 1'b1;
        S_RD: begin
          last_rx <= databus;
          if (!fifo_full) begin
            wr_ptr     <= wr_ptr + AW'(1);
            fifo_count <= fifo_count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        S_WR: begin
          rd_ptr       <= rd_ptr + AW'(1);
          fifo_count   <= fifo_count - 1'b1;
          tx_busy      <= 1'b1;
          tbr_low_seen <= 1'b0;
          first_tx     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RD && !fifo_full)
      fifo_mem[wr_ptr] <= databus;
  end

endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: SPART stand-in plus a transaction-level echo
// model checked every cycle, and directed scenarios with literal expectations.
module tb_spart_echo_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       auto_tbr = 1'b1;
  logic       tbr_man = 1'b1;
  int         tx_timer = 0;
  logic       tbr;
  logic       iocs, iorw, cfg_done, overflow;
  logic [1:0] ioaddr;
  logic [3:0] fifo_count;
  logic [7:0] last_rx;
  wire  [7:0] databus;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0, wr_cnt = 0, cfg_cnt = 0, cfg_low_cycles = 0;
  logic [7:0] last_wr = '0, last_cfg_lo = '0, last_cfg_hi = '0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_cfg = 1'b0, prev_wr = 1'b0;
  logic [7:0] m_last = '0;

  spart_echo_driver #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .cfg_done(cfg_done), .overflow(overflow), .fifo_count(fifo_count),
    .last_rx(last_rx)
  );

  always #5 clk = ~clk;

  // SPART stand-in: drives the rx byte on a buffer read; after each transmit
  // write, tbr drops for four cycles when in automatic mode.
  assign databus = (!iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'hzz;
  assign tbr = auto_tbr ? (tx_timer == 0) : tbr_man;

  always @(posedge clk) begin
    if (!iocs && !iorw && ioaddr == 2'b00) tx_timer <= 4;
    else if (tx_timer != 0)                tx_timer <= tx_timer - 1;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] div_of(input logic [1:0] b);
    case (b)
      2'b00:   return 16'h028A;
      2'b01:   return 16'h0144;
      2'b10:   return 16'h00A2;
      default: return 16'h0050;
    endcase
  endfunction

  // Echo model: every byte read is queued (or dropped when 8 are waiting),
  // every transmit write must carry the oldest waiting byte.
  always @(negedge clk) begin
    logic is_wr, is_rd, is_lo, is_hi;
    logic [15:0] dv;
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0; m_cfg = 1'b0; m_last = '0; prev_wr = 1'b0;
    end else begin
      is_wr = !iocs && !iorw && ioaddr == 2'b00;
      is_rd = !iocs &&  iorw && ioaddr == 2'b00;
      is_lo = !iocs && !iorw && ioaddr == 2'b10;
      is_hi = !iocs && !iorw && ioaddr == 2'b11;
      chk("fifo_count", 16'(fifo_count), 16'(mq.size()));
      chk("overflow", 16'(overflow), 16'(m_ovf));
      chk("last_rx", 16'(last_rx), 16'(m_last));
      if (is_lo) m_cfg = 1'b0;
      chk("cfg_done", 16'(cfg_done), 16'(m_cfg));
      if (!cfg_done) cfg_low_cycles++;
      dv = div_of(br_cfg);
      if (is_lo) begin
        chk("cfg_lo_data", 16'(databus), 16'(dv[7:0]));
        last_cfg_lo = databus; cfg_cnt++;
      end
      if (is_hi) begin
        chk("cfg_hi_data", 16'(databus), 16'(dv[15:8]));
        last_cfg_hi = databus; cfg_cnt++; m_cfg = 1'b1;
      end
      if (is_wr) begin
        chk("wr_back_to_back", 16'(prev_wr), 16'd0);
        chk("wr_when_nonempty", 16'(mq.size() != 0), 16'd1);
        if (mq.size() != 0) chk("wr_data", 16'(databus), 16'(mq.pop_front()));
        last_wr = databus; wr_cnt++;
      end
      if (is_rd) begin
        m_last = databus;
        if (mq.size() < 8) mq.push_back(databus);
        else               m_ovf = 1'b1;
        rd_cnt++;
      end
      prev_wr = is_wr;
    end
  end

  function automatic int cur(input int sel);
    if (sel == 0) return rd_cnt;
    if (sel == 1) return wr_cnt;
    return cfg_cnt;
  endfunction

  task automatic wait_cnt(input int sel, input int target, input string nm);
    int n;
    n = 0;
    while (cur(sel) < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(nm, 16'(cur(sel) >= target), 16'd1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int target;
    target = rd_cnt + 1;
    if (rda) begin
      rda = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    rx_byte = b;
    rda = 1'b1;
    wait_cnt(0, target, "rd_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, c0, n;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_iocs", 16'(iocs), 16'd1);
    chk("rst_iorw", 16'(iorw), 16'd1);
    chk("rst_ioaddr", 16'(ioaddr), 16'd1);
    chk("rst_cfg_done", 16'(cfg_done), 16'd0);
    chk("rst_fifo_count", 16'(fifo_count), 16'd0);
    chk("rst_last_rx", 16'(last_rx), 16'd0);
    rst = 1'b1;

    // Divisor programming after reset, br_cfg=01
    @(posedge clk); #1;
    chk("c1_ioaddr", 16'(ioaddr), 16'd2);
    chk("c1_iorw", 16'(iorw), 16'd0);
    chk("c1_data", 16'(databus), 16'h0044);
    @(posedge clk); #1;
    chk("c2_ioaddr", 16'(ioaddr), 16'd3);
    chk("c2_data", 16'(databus), 16'h0001);
    chk("c2_cfg_done", 16'(cfg_done), 16'd0);
    @(posedge clk); #1;
    chk("c3_cfg_done", 16'(cfg_done), 16'd1);
    chk("c3_ioaddr", 16'(ioaddr), 16'd1);
    chk("c3_iorw", 16'(iorw), 16'd1);

    // Single echo of A5
    r0 = rd_cnt; w0 = wr_cnt;
    send_byte(8'hA5);
    chk("a5_last_rx", 16'(last_rx), 16'h00A5);
    chk("a5_count", 16'(fifo_count), 16'd1);
    wait_cnt(1, w0 + 1, "wr_timeout");
    chk("a5_echo", 16'(last_wr), 16'h00A5);
    chk("a5_count_after", 16'(fifo_count), 16'd0);

    // rda held high: no duplicate read or echo
    repeat (100) @(posedge clk);
    #1;
    chk("hold_rd_cnt", 16'(rd_cnt - r0), 16'd1);
    chk("hold_wr_cnt", 16'(wr_cnt - w0), 16'd1);

    // tbr held low while 3 bytes queue up
    w0 = wr_cnt;
    send_byte(8'h11);
    wait_cnt(1, w0 + 1, "wr_timeout");
    chk("echo_11", 16'(last_wr), 16'h0011);
    auto_tbr = 1'b0; tbr_man = 1'b0;
    w0 = wr_cnt;
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (5) @(posedge clk);
    #1;
    chk("stuck_count", 16'(fifo_count), 16'd3);
    chk("stuck_no_wr", 16'(wr_cnt - w0), 16'd0);
    tbr_man = 1'b1;
    wait_cnt(1, w0 + 1, "wr_timeout");
    chk("echo_22", 16'(last_wr), 16'h0022);
    repeat (10) @(posedge clk);
    #1;
    chk("no_rearm_wr", 16'(wr_cnt - w0), 16'd1);
    chk("no_rearm_count", 16'(fifo_count), 16'd2);
    tbr_man = 1'b0;
    @(posedge clk); #1;
    tbr_man = 1'b1;
    wait_cnt(1, w0 + 2, "wr_timeout");
    chk("echo_33", 16'(last_wr), 16'h0033);
    auto_tbr = 1'b1;
    wait_cnt(1, w0 + 3, "wr_timeout");
    chk("echo_44", 16'(last_wr), 16'h0044);

    // Overflow: 9 bytes with tbr stuck low
    auto_tbr = 1'b0; tbr_man = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i));
    chk("full_count", 16'(fifo_count), 16'd8);
    chk("full_no_ovf", 16'(overflow), 16'd0);
    send_byte(8'h68);
    chk("ovf_count", 16'(fifo_count), 16'd8);
    chk("ovf_flag", 16'(overflow), 16'd1);
    chk("ovf_last_rx", 16'(last_rx), 16'h0068);
    auto_tbr = 1'b1;
    n = 0;
    while (fifo_count != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 16'(fifo_count), 16'd0);
    chk("drain_last", 16'(last_wr), 16'h0067);
    repeat (10) @(posedge clk);
    #1;

    // Baud change deferred while transmitting; FIFO kept across it
    auto_tbr = 1'b0; tbr_man = 1'b1;
    w0 = wr_cnt;
    send_byte(8'h77);
    wait_cnt(1, w0 + 1, "wr_timeout");
    c0 = cfg_cnt;
    br_cfg = 2'b11;
    send_byte(8'h88);
    repeat (20) @(posedge clk);
    #1;
    chk("defer_no_cfg", 16'(cfg_cnt - c0), 16'd0);
    chk("defer_cfg_done", 16'(cfg_done), 16'd1);
    chk("defer_count", 16'(fifo_count), 16'd1);
    cfg_low_cycles = 0;
    tbr_man = 1'b0;
    @(posedge clk); #1;
    tbr_man = 1'b1;
    wait_cnt(2, c0 + 2, "cfg_timeout");
    chk("recfg_lo", 16'(last_cfg_lo), 16'h0050);
    chk("recfg_hi", 16'(last_cfg_hi), 16'h0000);
    wait_cnt(1, w0 + 2, "wr_timeout");
    chk("echo_88", 16'(last_wr), 16'h0088);
    chk("cfg_low_cycles", 16'(cfg_low_cycles), 16'd2);

    // Asynchronous reset mid-operation
    tbr_man = 1'b0;
    send_byte(8'h99);
    chk("pre_rst_count", 16'(fifo_count), 16'd1);
    chk("pre_rst_ovf", 16'(overflow), 16'd1);
    rda = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_iocs", 16'(iocs), 16'd1);
    chk("mid_rst_ioaddr", 16'(ioaddr), 16'd1);
    chk("mid_rst_ovf", 16'(overflow), 16'd0);
    chk("mid_rst_count", 16'(fifo_count), 16'd0);
    chk("mid_rst_last_rx", 16'(last_rx), 16'd0);
    chk("mid_rst_cfg_done", 16'(cfg_done), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    auto_tbr = 1'b1;
    @(posedge clk); #1;
    chk("restart_ioaddr", 16'(ioaddr), 16'd2);
    chk("restart_data", 16'(databus), 16'h0050);
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
